// File: rtl/centroid_tracker_if.sv
// Pixel-stream and centroid-result bundle between the mask pipeline, the tracker and its consumers.
interface centroid_tracker_if #(
  parameter int H_W = 11,
  parameter int V_W = 10
);
  logic [H_W-1:0] hcount_in;
  logic [V_W-1:0] vcount_in;
  logic           valid_in;
  logic           mask_in;
  logic           frame_done_in;
  logic [H_W-1:0] x_out;
  logic [V_W-1:0] y_out;
  logic           valid_out;
  logic           busy_out;
  logic           crosshair_out;

  modport master (
    output hcount_in, vcount_in, valid_in, mask_in, frame_done_in,
    input  x_out, y_out, valid_out, busy_out, crosshair_out
  );

  modport slave (
    input  hcount_in, vcount_in, valid_in, mask_in, frame_done_in,
    output x_out, y_out, valid_out, busy_out, crosshair_out
  );
endinterface

// File: rtl/centroid_tracker.sv
// Per-frame centroid of the thresholded mask: x/y sums and set-pixel count,
// divided at end of frame by two parallel restoring dividers; drives the crosshair overlay.
//
// state  | meaning
// ACCUM  | waiting for frame_done_in, divider idle
// DIVIDE | one quotient bit per cycle for both axes, SUM_W cycles
// DONE   | load quotients into x/y outputs and raise valid_out for the next cycle
module centroid_tracker #(
  parameter int H_W   = 11,
  parameter int V_W   = 10,
  parameter int SUM_W = 32,
  parameter int CNT_W = 20
) (
  input logic               clk_in,
  input logic               rst_n_in,
  centroid_tracker_if.slave px
);

  localparam int IT_W = $clog2(SUM_W);

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_x_q, sum_y_q;
  logic [CNT_W-1:0]   count_q;
  logic [SUM_W-1:0]   dvd_x_q, dvd_y_q, dvd_x_d, dvd_y_d;
  logic [CNT_W-1:0]   rem_x_q, rem_y_q, rem_x_d, rem_y_d;
  logic [CNT_W-1:0]   div_q;
  logic [IT_W-1:0]    iter_q;
  logic [H_W-1:0]     x_q;
  logic [V_W-1:0]     y_q;
  logic               valid_q;
  logic               cross_q;
  logic               pix_hit;
  logic               snap_en;
  logic               out_en;
  logic [CNT_W:0]     trial_x, trial_y;
  logic               ge_x, ge_y;

  assign pix_hit = px.valid_in & px.mask_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ACCUM;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      ACCUM: begin
        if (px.frame_done_in && (count_q != '0)) begin
          snap_en = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (iter_q == '0) state_d = DONE;
      end
      DONE: begin
        out_en  = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // A pixel coincident with frame_done seeds the next frame instead of the snapshot.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
      count_q <= '0;
    end else if (px.frame_done_in) begin
      sum_x_q <= pix_hit ? SUM_W'(px.hcount_in) : '0;
      sum_y_q <= pix_hit ? SUM_W'(px.vcount_in) : '0;
      count_q <= pix_hit ? CNT_W'(1) : '0;
    end else if (pix_hit) begin
      sum_x_q <= sum_x_q + SUM_W'(px.hcount_in);
      sum_y_q <= sum_y_q + SUM_W'(px.vcount_in);
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Remainder is always below the divisor, so the subtraction fits in CNT_W bits.
  always_comb begin
    trial_x = {rem_x_q, dvd_x_q[SUM_W-1]};
    trial_y = {rem_y_q, dvd_y_q[SUM_W-1]};
    ge_x    = trial_x >= {1'b0, div_q};
    ge_y    = trial_y >= {1'b0, div_q};
    rem_x_d = ge_x ? (trial_x[CNT_W-1:0] - div_q) : trial_x[CNT_W-1:0];
    rem_y_d = ge_y ? (trial_y[CNT_W-1:0] - div_q) : trial_y[CNT_W-1:0];
    dvd_x_d = {dvd_x_q[SUM_W-2:0], ge_x};
    dvd_y_d = {dvd_y_q[SUM_W-2:0], ge_y};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dvd_x_q <= '0;
      dvd_y_q <= '0;
      rem_x_q <= '0;
      rem_y_q <= '0;
      div_q   <= '0;
      iter_q  <= '0;
    end else if (snap_en) begin
      dvd_x_q <= sum_x_q;
      dvd_y_q <= sum_y_q;
      rem_x_q <= '0;
      rem_y_q <= '0;
      div_q   <= count_q;
      iter_q  <= IT_W'(SUM_W - 1);
    end else if (state_q == DIVIDE) begin
      dvd_x_q <= dvd_x_d;
      dvd_y_q <= dvd_y_d;
      rem_x_q <= rem_x_d;
      rem_y_q <= rem_y_d;
      iter_q  <= iter_q - IT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      cross_q <= 1'b0;
    end else begin
      if (out_en) begin
        x_q <= dvd_x_q[H_W-1:0];
        y_q <= dvd_y_q[V_W-1:0];
      end
      valid_q <= out_en;
      cross_q <= (px.hcount_in == x_q) || (px.vcount_in == y_q);
    end
  end

  assign px.x_out         = x_q;
  assign px.y_out         = y_q;
  assign px.valid_out     = valid_q;
  assign px.busy_out      = (state_q == DIVIDE);
  assign px.crosshair_out = cross_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: hand-computed centroids, latency, frame-boundary and reset cases.
module tb_centroid_tracker;

  localparam int H_W   = 11;
  localparam int V_W   = 10;
  localparam int SUM_W = 32;
  localparam int CNT_W = 20;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   lat;
  int   bcnt;

  centroid_tracker_if #(.H_W(H_W), .V_W(V_W)) px ();

  centroid_tracker #(.H_W(H_W), .V_W(V_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .px      (px.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pix(input int h, input int v);
    px.hcount_in = H_W'(h);
    px.vcount_in = V_W'(v);
    px.valid_in  = 1'b1;
    px.mask_in   = 1'b1;
    tick();
    px.valid_in  = 1'b0;
    px.mask_in   = 1'b0;
  endtask

  task automatic pulse_fd();
    px.frame_done_in = 1'b1;
    tick();
    px.frame_done_in = 1'b0;
  endtask

  // lat = edges since the call until valid_out seen (budget if never); bc = busy cycles seen.
  task automatic wait_valid(input int budget, output int l, output int bc);
    l  = 0;
    bc = 0;
    while (l < budget && px.valid_out !== 1'b1) begin
      if (px.busy_out === 1'b1) bc++;
      tick();
      l++;
    end
  endtask

  initial begin
    px.hcount_in     = '0;
    px.vcount_in     = '0;
    px.valid_in      = 1'b0;
    px.mask_in       = 1'b0;
    px.frame_done_in = 1'b0;
    #3;
    chk("rst_x", 32'(px.x_out), 0);
    chk("rst_y", 32'(px.y_out), 0);
    chk("rst_valid", 32'(px.valid_out), 0);
    chk("rst_busy", 32'(px.busy_out), 0);
    chk("rst_cross", 32'(px.crosshair_out), 0);
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();

    // single pixel: 33-edge latency, 32 busy cycles
    pix(100, 50);
    pulse_fd();
    wait_valid(60, lat, bcnt);
    chk("t1_latency", 32'(lat), 33);
    chk("t1_busy_cycles", 32'(bcnt), 32);
    chk("t1_x", 32'(px.x_out), 100);
    chk("t1_y", 32'(px.y_out), 50);
    tick();
    chk("t1_valid_pulse", 32'(px.valid_out), 0);

    // empty frame: nothing happens, result holds
    pulse_fd();
    wait_valid(40, lat, bcnt);
    chk("t3_no_valid", 32'(lat), 40);
    chk("t3_no_busy", 32'(bcnt), 0);
    chk("t3_x_hold", 32'(px.x_out), 100);
    chk("t3_y_hold", 32'(px.y_out), 50);

    // four pixels: sums 44/83 over 4
    pix(10, 20);
    pix(11, 20);
    pix(10, 21);
    pix(13, 22);
    pulse_fd();
    wait_valid(60, lat, bcnt);
    chk("t2_latency", 32'(lat), 33);
    chk("t2_x", 32'(px.x_out), 11);
    chk("t2_y", 32'(px.y_out), 20);

    // second frame_done 10 cycles into DIVIDE is discarded
    pix(30, 40);
    pulse_fd();
    pix(600, 300);
    repeat (8) tick();
    pulse_fd();
    wait_valid(60, lat, bcnt);
    chk("t4_latency", 32'(lat), 23);
    chk("t4_x", 32'(px.x_out), 30);
    chk("t4_y", 32'(px.y_out), 40);
    tick();
    wait_valid(40, lat, bcnt);
    chk("t4_no_extra_valid", 32'(lat), 40);
    pix(5, 5);
    pulse_fd();
    wait_valid(60, lat, bcnt);
    chk("t4_x_fresh", 32'(px.x_out), 5);
    chk("t4_y_fresh", 32'(px.y_out), 5);

    // coincident frame_done and pixel: pixel belongs to the next frame
    tick();
    pulse_fd();
    wait_valid(40, lat, bcnt);
    chk("t5_empty_prior", 32'(lat), 40);
    px.hcount_in     = H_W'(200);
    px.vcount_in     = V_W'(100);
    px.valid_in      = 1'b1;
    px.mask_in       = 1'b1;
    px.frame_done_in = 1'b1;
    tick();
    px.valid_in      = 1'b0;
    px.mask_in       = 1'b0;
    px.frame_done_in = 1'b0;
    wait_valid(40, lat, bcnt);
    chk("t5_no_result", 32'(lat), 40);
    chk("t5_no_busy", 32'(bcnt), 0);
    pulse_fd();
    wait_valid(60, lat, bcnt);
    chk("t5_x", 32'(px.x_out), 200);
    chk("t5_y", 32'(px.y_out), 100);

    // crosshair against centroid (100,50)
    tick();
    pix(100, 50);
    pulse_fd();
    wait_valid(60, lat, bcnt);
    chk("t6_x", 32'(px.x_out), 100);
    chk("t6_y", 32'(px.y_out), 50);
    px.hcount_in = H_W'(100);
    px.vcount_in = V_W'(0);
    tick();
    chk("t6_cross_h", 32'(px.crosshair_out), 1);
    px.hcount_in = H_W'(101);
    px.vcount_in = V_W'(49);
    tick();
    chk("t6_cross_off", 32'(px.crosshair_out), 0);
    px.hcount_in = H_W'(5);
    px.vcount_in = V_W'(50);
    tick();
    chk("t6_cross_v", 32'(px.crosshair_out), 1);

    // reset 15 cycles into DIVIDE
    pix(7, 9);
    pulse_fd();
    repeat (15) tick();
    chk("t7_busy_before", 32'(px.busy_out), 1);
    rst_n_in = 1'b0;
    #1;
    chk("t7_rst_x", 32'(px.x_out), 0);
    chk("t7_rst_y", 32'(px.y_out), 0);
    chk("t7_rst_busy", 32'(px.busy_out), 0);
    chk("t7_rst_valid", 32'(px.valid_out), 0);
    chk("t7_rst_cross", 32'(px.crosshair_out), 0);
    tick();
    rst_n_in = 1'b1;
    wait_valid(50, lat, bcnt);
    chk("t7_no_valid", 32'(lat), 50);
    chk("t7_no_busy", 32'(bcnt), 0);
    chk("t7_x_after", 32'(px.x_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/centroid_tracker.md
Name: centroid_tracker

Overview:
- Sits directly upstream of the display mux. Consumes the thresholded mask pixel stream, accumulates the x/y sums and the count of set pixels over each frame, and divides at end of frame with a serial divider to get the centroid.
- Produces the 1-bit crosshair overlay signal for the mux, plus the centroid coordinates for downstream sprite logic.

Parameters:
- H_W, 11, width of the horizontal pixel coordinate.
- V_W, 10, width of the vertical pixel coordinate.
- SUM_W, 32, width of the x/y sum accumulators and the divider dividend.
- CNT_W, 20, width of the set-pixel counter and the divisor.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- hcount_in  input  H_W  x coordinate of the current pixel.
- vcount_in  input  V_W  y coordinate of the current pixel.
- valid_in  input  1  current pixel is in the active area.
- mask_in  input  1  thresholded pixel; 1 = pixel belongs to the object.
- frame_done_in  input  1  single-cycle pulse at the end of the active frame.
- x_out  output  H_W  centroid x, floor(sum_x/count).
- y_out  output  V_W  centroid y, floor(sum_y/count).
- valid_out  output  1  one-cycle pulse when x_out/y_out update.
- busy_out  output  1  high while the divider is running.
- crosshair_out  output  1  registered: (hcount_in==x_out) or (vcount_in==y_out).

Behaviour:
- Reset: async assert on rst_n_in low. All of the following clear immediately and hold until the first clk_in edge after release: x_out=0, y_out=0, valid_out=0, busy_out=0, crosshair_out=0, accumulators=0, state=ACCUM.
- Accumulation runs in every state. On a cycle with valid_in & mask_in: sum_x += hcount_in, sum_y += vcount_in, count += 1, all zero-extended.
  - Widths are sized so 1024x768 cannot overflow; no saturation logic.
- frame_done_in in ACCUM:
  - If count != 0: snapshot sum_x, sum_y, count into the divider registers and enter DIVIDE.
  - If count == 0: no division; x_out/y_out hold; no valid_out pulse.
  - In both cases, clear the accumulators.
- frame_done_in in DIVIDE: clear the accumulators; discard the new snapshot; the in-progress division continues unaffected.
- Simultaneous frame_done_in and a valid mask pixel: the pixel is NOT in the snapshot. The cleared accumulators take that pixel, so the next frame starts at count=1.
- States and transitions:
  - ACCUM: waiting for frame_done_in; busy_out=0.
  - DIVIDE: two restoring dividers (x and y) run in parallel, one quotient bit per cycle, MSB first, SUM_W iterations; busy_out=1.
  - DONE: one cycle. x_out <= quotient_x[H_W-1:0], y_out <= quotient_y[V_W-1:0], valid_out=1, then return to ACCUM.
  - Quotient upper bits are zero by construction.
- Latency: frame_done_in sampled at edge T → DIVIDE from T+1 through T+SUM_W → valid_out high in cycle T+SUM_W+1 (33 cycles for SUM_W=32).
  - x_out/y_out change only in the valid_out cycle.
- Division: unsigned, truncating (floor).
- crosshair_out: one-cycle registered latency, compared against the current x_out/y_out. The upstream pixel pipeline must delay the camera pixel by 1 to match.
- Reset mid-DIVIDE: the division is aborted, outputs clear, and no valid_out is issued afterwards.

Test Plan:
- Single set pixel at (100,50), then frame_done_in → exactly 33 cycles later valid_out=1, x_out=100, y_out=50; busy_out high for exactly 32 cycles.
- Four set pixels at (10,20),(11,20),(10,21),(13,22) → x_out=floor(44/4)=11, y_out=floor(83/4)=20.
- Frame with no set pixels after a frame with centroid (100,50) → no valid_out, busy_out stays 0, x_out=100, y_out=50 hold.
- Second frame_done_in 10 cycles into DIVIDE → first result completes unchanged. A set pixel (5,5) fed next, then frame_done_in in ACCUM → x_out=5, y_out=5, with no contribution from the pre-clear frame.
- frame_done_in coincident with mask at (200,100), prior frame empty → no result for that frame. Next frame_done_in → x_out=200, y_out=100.
- rst_n_in low at cycle 15 of DIVIDE → all outputs 0 immediately; no valid_out after release. With x_out=100, y_out=50, hcount=100 → crosshair_out=1 one cycle later; with hcount=101, vcount=49 → crosshair_out=0.
